// File: rtl/bip_program_loader_pkg.sv
// Shared types and stream-format constants for the BIP program loader.
package bip_program_loader_pkg;

  // Loader FSM states, 3-bit encoding.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLenLo  = 3'd1,
    StLenHi  = 3'd2,
    StDataLo = 3'd3,
    StDataHi = 3'd4,
    StCheck  = 3'd5,
    StRun    = 3'd6,
    StError  = 3'd7
  } loader_state_e;

  // Stream framing: little-endian length header, trailing XOR checksum byte.
  localparam int unsigned LEN_BYTES = 2;
  localparam int unsigned CHK_BYTES = 1;

  // Total bytes in a stream carrying n_words instruction words.
  function automatic int unsigned stream_bytes(input int unsigned n_words);
    return LEN_BYTES + 2 * n_words + CHK_BYTES;
  endfunction

endpackage

// File: rtl/bip_loader_word_assembler.sv
// Pairs LO/HI bytes into one instruction word and issues a single-cycle memory write.
module bip_loader_word_assembler #(
  parameter int unsigned NB_DATA = 16,
  parameter int unsigned NB_BYTE = 8,
  parameter int unsigned ADDR_W  = 11
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               lo_load_i,
  input  logic               hi_load_i,
  input  logic [NB_BYTE-1:0] byte_i,
  input  logic [ADDR_W-1:0]  addr_i,
  output logic               wr_en_o,
  output logic [ADDR_W-1:0]  wr_addr_o,
  output logic [NB_DATA-1:0] wr_data_o
);

  logic [NB_BYTE-1:0] lo_q, lo_d;
  logic               en_q, en_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [NB_DATA-1:0] data_q, data_d;

  // Next-state: latch LO; on HI capture the full word and fire the strobe for one cycle.
  always_comb begin
    lo_d   = lo_q;
    en_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (lo_load_i) begin
      lo_d = byte_i;
    end
    if (hi_load_i) begin
      en_d   = 1'b1;
      addr_d = addr_i;
      data_d = NB_DATA'({byte_i, lo_q});
    end
  end

  // Word/strobe registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lo_q   <= '0;
      en_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      lo_q   <= lo_d;
      en_q   <= en_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign wr_en_o   = en_q;
  assign wr_addr_o = addr_q;
  assign wr_data_o = data_q;

endmodule

// File: rtl/bip_program_loader.sv
// Byte-stream loader: fills BIP instruction memory, verifies an XOR checksum,
// then releases the CPU via o_cpu_valid.
module bip_program_loader
  import bip_program_loader_pkg::*;
#(
  parameter int unsigned NB_DATA            = 16,
  parameter int unsigned NB_BYTE            = 8,
  parameter int unsigned N_INSMEM_ADDR      = 2048,
  parameter int unsigned LOG2_N_INSMEM_ADDR = 11,
  parameter int unsigned NB_COUNT           = 16
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [NB_BYTE-1:0]            i_rx_data,
  input  logic                          i_rx_valid,
  input  logic                          i_start,
  output logic                          o_wr_en,
  output logic [LOG2_N_INSMEM_ADDR-1:0] o_wr_addr,
  output logic [NB_DATA-1:0]            o_wr_data,
  output logic                          o_cpu_valid,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_error,
  output logic [NB_COUNT-1:0]           o_word_count
);

  localparam logic [NB_COUNT-1:0] MaxWords = NB_COUNT'(N_INSMEM_ADDR);

  loader_state_e       state_q, state_d;
  logic [NB_COUNT-1:0] len_q, len_d;
  logic [NB_COUNT-1:0] count_q, count_d;
  logic [NB_BYTE-1:0]  xor_q, xor_d;
  logic [NB_COUNT-1:0] len_rx;
  logic [NB_COUNT-1:0] count_inc;
  logic                lo_load, hi_load;

  assign len_rx    = NB_COUNT'({i_rx_data, len_q[NB_BYTE-1:0]});
  assign count_inc = count_q + NB_COUNT'(1);

  // Next-state logic: header parse, word sequencing and checksum compare.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    xor_d   = xor_q;
    lo_load = 1'b0;
    hi_load = 1'b0;
    unique case (state_q)
      StIdle, StRun, StError: begin
        // Any byte arriving with i_start is dropped on purpose.
        if (i_start) begin
          state_d = StLenLo;
          count_d = '0;
          xor_d   = '0;
        end
      end
      StLenLo: begin
        if (i_rx_valid) begin
          len_d   = NB_COUNT'(i_rx_data);
          xor_d   = xor_q ^ i_rx_data;
          state_d = StLenHi;
        end
      end
      StLenHi: begin
        if (i_rx_valid) begin
          len_d = len_rx;
          xor_d = xor_q ^ i_rx_data;
          if (len_rx == '0) begin
            state_d = StCheck;
          end else if (len_rx > MaxWords) begin
            state_d = StError;
          end else begin
            state_d = StDataLo;
          end
        end
      end
      StDataLo: begin
        if (i_rx_valid) begin
          lo_load = 1'b1;
          xor_d   = xor_q ^ i_rx_data;
          state_d = StDataHi;
        end
      end
      StDataHi: begin
        if (i_rx_valid) begin
          hi_load = 1'b1;
          xor_d   = xor_q ^ i_rx_data;
          count_d = count_inc;
          state_d = (count_inc == len_q) ? StCheck : StDataLo;
        end
      end
      StCheck: begin
        if (i_rx_valid) begin
          state_d = (i_rx_data == xor_q) ? StRun : StError;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any load in progress.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q <= StIdle;
      len_q   <= '0;
      count_q <= '0;
      xor_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      xor_q   <= xor_d;
    end
  end

  // The word index captured here is the pre-increment count, i.e. the current address.
  bip_loader_word_assembler #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE),
    .ADDR_W  (LOG2_N_INSMEM_ADDR)
  ) u_word_assembler (
    .clk_i     (i_clock),
    .rst_ni    (i_reset),
    .lo_load_i (lo_load),
    .hi_load_i (hi_load),
    .byte_i    (i_rx_data),
    .addr_i    (count_q[LOG2_N_INSMEM_ADDR-1:0]),
    .wr_en_o   (o_wr_en),
    .wr_addr_o (o_wr_addr),
    .wr_data_o (o_wr_data)
  );

  // Status flags decode straight from the state register.
  assign o_busy       = (state_q == StLenLo) || (state_q == StLenHi) || (state_q == StDataLo) ||
                        (state_q == StDataHi) || (state_q == StCheck);
  assign o_done       = (state_q == StRun);
  assign o_cpu_valid  = (state_q == StRun);
  assign o_error      = (state_q == StError);
  assign o_word_count = count_q;

endmodule

// File: tb/tb_bip_program_loader.sv
// Directed self-checking bench for bip_program_loader.
module tb_bip_program_loader;

  logic        i_clock;
  logic        i_reset;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        i_start;
  logic        o_wr_en;
  logic [10:0] o_wr_addr;
  logic [15:0] o_wr_data;
  logic        o_cpu_valid;
  logic        o_busy;
  logic        o_done;
  logic        o_error;
  logic [15:0] o_word_count;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [7:0]  stim[$];
  logic [10:0] log_addr[$];
  logic [15:0] log_data[$];
  int          log_cyc[$];

  bip_program_loader dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .i_start      (i_start),
    .o_wr_en      (o_wr_en),
    .o_wr_addr    (o_wr_addr),
    .o_wr_data    (o_wr_data),
    .o_cpu_valid  (o_cpu_valid),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_error      (o_error),
    .o_word_count (o_word_count)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  // Write monitor: logs every memory write seen mid-cycle.
  always @(negedge i_clock) begin
    cyc = cyc + 1;
    if (o_wr_en === 1'b1) begin
      log_addr.push_back(o_wr_addr);
      log_data.push_back(o_wr_data);
      log_cyc.push_back(cyc);
    end
  end

  // Drive stim[] on consecutive cycles (back-to-back strobes).
  task automatic send_stim();
    foreach (stim[i]) begin
      @(negedge i_clock);
      i_rx_data  = stim[i];
      i_rx_valid = 1'b1;
    end
    @(negedge i_clock);
    i_rx_valid = 1'b0;
    #1;
  endtask

  task automatic pulse_start();
    @(negedge i_clock);
    i_start = 1'b1;
    @(negedge i_clock);
    i_start = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    i_reset = 1'b0;
    repeat (2) @(negedge i_clock);
    #1;
    vectors++;
    if ({o_wr_en, o_wr_addr, o_wr_data, o_cpu_valid, o_busy, o_done, o_error, o_word_count}
        !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got en=%b addr=%0h data=%0h cv=%b busy=%b done=%b err=%b wc=%0d, want all 0",
               o_wr_en, o_wr_addr, o_wr_data, o_cpu_valid, o_busy, o_done, o_error, o_word_count);
    end
    @(negedge i_clock);
    i_reset = 1'b1;
  endtask

  task automatic test_basic();
    int base;
    base = log_addr.size();
    pulse_start();
    vectors++;
    if (o_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_armed: busy=%b want 1", o_busy);
    end
    stim = '{8'h02, 8'h00, 8'h01, 8'h08};
    send_stim();
    vectors++;
    if (o_wr_en !== 1'b1 || o_wr_addr !== 11'd0 || o_wr_data !== 16'h0801) begin
      miscompares++;
      $display("FAIL basic_latency: en=%b addr=%0h data=%h want 1/0/0801",
               o_wr_en, o_wr_addr, o_wr_data);
    end
    vectors++;
    if (o_word_count !== 16'd1) begin
      miscompares++;
      $display("FAIL basic_count_step: wc=%0d want 1", o_word_count);
    end
    stim = '{8'h02, 8'h10, 8'h19};
    send_stim();
    vectors++;
    if (log_addr.size() - base !== 2) begin
      miscompares++;
      $display("FAIL basic_nwrites: got %0d want 2", log_addr.size() - base);
    end else if (log_addr[base+1] !== 11'd1 || log_data[base+1] !== 16'h1002) begin
      miscompares++;
      $display("FAIL basic_write1: addr=%0h data=%h want 1/1002",
               log_addr[base+1], log_data[base+1]);
    end
    vectors++;
    if (o_done !== 1'b1 || o_cpu_valid !== 1'b1 || o_busy !== 1'b0 || o_error !== 1'b0
        || o_word_count !== 16'd2) begin
      miscompares++;
      $display("FAIL basic_run: done=%b cv=%b busy=%b err=%b wc=%0d want 1/1/0/0/2",
               o_done, o_cpu_valid, o_busy, o_error, o_word_count);
    end
  endtask

  task automatic test_bad_chk();
    int base;
    base = log_addr.size();
    pulse_start();
    vectors++;
    if (o_done !== 1'b0 || o_cpu_valid !== 1'b0 || o_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rearm_from_run: done=%b cv=%b busy=%b want 0/0/1", o_done, o_cpu_valid,
               o_busy);
    end
    stim = '{8'h02, 8'h00, 8'h01, 8'h08, 8'h02, 8'h10, 8'h18};
    send_stim();
    vectors++;
    if (log_addr.size() - base !== 2) begin
      miscompares++;
      $display("FAIL badchk_nwrites: got %0d want 2", log_addr.size() - base);
    end else if (log_data[base] !== 16'h0801 || log_data[base+1] !== 16'h1002) begin
      miscompares++;
      $display("FAIL badchk_data: got %h %h want 0801 1002", log_data[base], log_data[base+1]);
    end
    vectors++;
    if (o_error !== 1'b1 || o_cpu_valid !== 1'b0 || o_done !== 1'b0) begin
      miscompares++;
      $display("FAIL badchk_error: err=%b cv=%b done=%b want 1/0/0", o_error, o_cpu_valid, o_done);
    end
  endtask

  task automatic test_too_long();
    int base;
    base = log_addr.size();
    pulse_start();
    stim = '{8'h01, 8'h08};
    send_stim();
    vectors++;
    if (o_error !== 1'b1 || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL toolong_error: err=%b busy=%b want 1/0", o_error, o_busy);
    end
    stim = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_stim();
    vectors++;
    if (log_addr.size() !== base || o_error !== 1'b1) begin
      miscompares++;
      $display("FAIL toolong_nowrite: writes=%0d err=%b want 0/1", log_addr.size() - base, o_error);
    end
  endtask

  task automatic test_empty_and_rearm();
    int base;
    base = log_addr.size();
    pulse_start();
    stim = '{8'h00, 8'h00, 8'h00};
    send_stim();
    vectors++;
    if (o_done !== 1'b1 || o_cpu_valid !== 1'b1 || o_word_count !== 16'd0
        || log_addr.size() !== base) begin
      miscompares++;
      $display("FAIL empty_run: done=%b cv=%b wc=%0d writes=%0d want 1/1/0/0",
               o_done, o_cpu_valid, o_word_count, log_addr.size() - base);
    end
    pulse_start();
    vectors++;
    if (o_cpu_valid !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL empty_rearm: cv=%b done=%b busy=%b want 0/0/1", o_cpu_valid, o_done, o_busy);
    end
  endtask

  // Entered in LEN_LO; a start pulse mid-load must not disturb the stream.
  task automatic test_start_ignored();
    int base;
    base = log_addr.size();
    stim = '{8'h01, 8'h00};
    send_stim();
    pulse_start();
    stim = '{8'h34, 8'h12, 8'h27};
    send_stim();
    vectors++;
    if (log_addr.size() - base !== 1) begin
      miscompares++;
      $display("FAIL ignstart_nwrites: got %0d want 1", log_addr.size() - base);
    end else if (log_addr[base] !== 11'd0 || log_data[base] !== 16'h1234) begin
      miscompares++;
      $display("FAIL ignstart_write: addr=%0h data=%h want 0/1234", log_addr[base], log_data[base]);
    end
    vectors++;
    if (o_done !== 1'b1 || o_word_count !== 16'd1) begin
      miscompares++;
      $display("FAIL ignstart_run: done=%b wc=%0d want 1/1", o_done, o_word_count);
    end
  endtask

  // Start and a byte together in RUN: byte dropped, header parse starts fresh.
  task automatic test_start_rx_collide();
    @(negedge i_clock);
    i_start    = 1'b1;
    i_rx_valid = 1'b1;
    i_rx_data  = 8'h05;
    @(negedge i_clock);
    i_start    = 1'b0;
    i_rx_valid = 1'b0;
    #1;
    vectors++;
    if (o_busy !== 1'b1 || o_done !== 1'b0) begin
      miscompares++;
      $display("FAIL collide_arm: busy=%b done=%b want 1/0", o_busy, o_done);
    end
    stim = '{8'h00, 8'h00, 8'h00};
    send_stim();
    vectors++;
    if (o_done !== 1'b1 || o_word_count !== 16'd0) begin
      miscompares++;
      $display("FAIL collide_drop: done=%b wc=%0d want 1/0", o_done, o_word_count);
    end
  endtask

  task automatic test_reset_midload();
    int base;
    pulse_start();
    stim = '{8'h02, 8'h00, 8'h01};
    send_stim();
    @(negedge i_clock);
    i_reset = 1'b0;
    @(negedge i_clock);
    #1;
    vectors++;
    if ({o_wr_en, o_wr_addr, o_wr_data, o_cpu_valid, o_busy, o_done, o_error, o_word_count}
        !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs: en=%b addr=%0h data=%h cv=%b busy=%b done=%b err=%b wc=%0d want all 0",
               o_wr_en, o_wr_addr, o_wr_data, o_cpu_valid, o_busy, o_done, o_error, o_word_count);
    end
    i_reset = 1'b1;
    base = log_addr.size();
    stim = '{8'h08, 8'h02, 8'h10, 8'h19, 8'h02, 8'h00, 8'h01, 8'h08};
    send_stim();
    vectors++;
    if (log_addr.size() !== base || o_busy !== 1'b0 || o_done !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_idle: writes=%0d busy=%b done=%b want 0/0/0",
               log_addr.size() - base, o_busy, o_done);
    end
  endtask

  task automatic test_full_depth();
    int          base;
    int          n;
    int          bad_addr;
    int          bad_gap;
    logic [7:0]  chk;
    logic [15:0] w;
    base = log_addr.size();
    pulse_start();
    stim.delete();
    stim.push_back(8'h00);
    stim.push_back(8'h08);
    chk = 8'h08;
    for (int a = 0; a < 2048; a++) begin
      w = a[15:0];
      stim.push_back(w[7:0]);
      stim.push_back(w[15:8]);
      chk = chk ^ w[7:0] ^ w[15:8];
    end
    stim.push_back(chk);
    send_stim();
    n = log_addr.size() - base;
    vectors++;
    if (n !== 2048) begin
      miscompares++;
      $display("FAIL full_nwrites: got %0d want 2048", n);
    end
    bad_addr = 0;
    bad_gap  = 0;
    for (int i = 0; i < n && i < 2048; i++) begin
      w = i[15:0];
      if (log_addr[base+i] !== w[10:0] || log_data[base+i] !== w) bad_addr++;
      if (i > 0 && log_cyc[base+i] - log_cyc[base+i-1] !== 2) bad_gap++;
    end
    vectors++;
    if (bad_addr !== 0) begin
      miscompares++;
      $display("FAIL full_addr_data: %0d bad writes, want 0", bad_addr);
    end
    vectors++;
    if (bad_gap !== 0) begin
      miscompares++;
      $display("FAIL full_spacing: %0d irregular gaps, want 0", bad_gap);
    end
    vectors++;
    if (o_word_count !== 16'd2048 || o_done !== 1'b1 || o_cpu_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL full_run: wc=%0d done=%b cv=%b want 2048/1/1", o_word_count, o_done,
               o_cpu_valid);
    end
  endtask

  initial begin
    i_reset    = 1'b0;
    i_rx_data  = 8'h00;
    i_rx_valid = 1'b0;
    i_start    = 1'b0;
    test_reset();
    test_basic();
    test_bad_chk();
    test_too_long();
    test_empty_and_rearm();
    test_start_ignored();
    test_start_rx_collide();
    test_reset_midload();
    test_full_depth();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bip_program_loader.md
Name: bip_program_loader

Overview:
Writer side of the BIP program memory: a byte-stream loader that fills instruction memory and then releases the CPU.
- Consumes 8-bit bytes from a UART receiver.
- Assembles 16-bit instruction words and writes them sequentially from address 0.
- Verifies an XOR checksum over the stream.
- On success drives the BIP top's i_valid (o_cpu_valid) to start execution; the CPU stays held otherwise.

Parameters:
NB_DATA, 16, instruction word width
NB_BYTE, 8, received byte width
N_INSMEM_ADDR, 2048, program memory depth (maximum word count)
LOG2_N_INSMEM_ADDR, 11, program memory address width
NB_COUNT, 16, width of the length field in the stream header

Ports:
i_clock  in  1  system clock, rising edge
i_reset  in  1  synchronous reset, active-low (0 = reset)
i_rx_data  in  NB_BYTE  received byte
i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
i_start  in  1  one-cycle pulse, arm loader for a new stream
o_wr_en  out  1  program memory write strobe
o_wr_addr  out  LOG2_N_INSMEM_ADDR  program memory write address
o_wr_data  out  NB_DATA  program memory write data
o_cpu_valid  out  1  drives BIP i_valid; high only in RUN
o_busy  out  1  high in LEN_LO..CHECK
o_done  out  1  high in RUN
o_error  out  1  high in ERROR
o_word_count  out  NB_COUNT  words written in the current stream

Behaviour:
- Reset (i_reset==0 at a clock edge): state=IDLE and every output is 0. Memory contents are not cleared. Reset mid-load aborts immediately with no further write.
- Stream format, all bytes on i_rx_valid strobes: LEN_LO, LEN_HI (N, little-endian), then N words as (LO, HI), then one CHK byte.
- CHK must equal the XOR of all preceding bytes, including the length bytes.
- States: IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHECK, RUN, ERROR.
- IDLE: on i_start go to LEN_LO; clear word counter, address and running XOR.
- LEN_LO/LEN_HI: latch the bytes.
- After LEN_HI:
  - N==0: go to CHECK.
  - N>N_INSMEM_ADDR: go to ERROR.
  - Otherwise go to DATA_LO.
- DATA_LO: latch the low byte, go to DATA_HI.
- DATA_HI: on the strobe, in the next cycle o_wr_en=1 for exactly one cycle, with:
  - o_wr_addr = current word index;
  - o_wr_data = {HI, LO}.
  - The word counter and address increment on that same edge.
  - When the last word is captured, go to CHECK; otherwise go to DATA_LO.
- Write latency: exactly 1 cycle from the HI-byte strobe. Back-to-back strobes on consecutive cycles must be accepted with no byte lost.
- CHECK: on the strobe, compare the byte to the running XOR.
  - Equal: go to RUN.
  - Not equal: go to ERROR.
- RUN: o_cpu_valid=1, o_done=1.
- ERROR: o_error=1, o_cpu_valid=0. Words already written remain in memory.
- i_start is honoured only in IDLE, RUN and ERROR; it re-arms to LEN_LO and drops o_cpu_valid/o_done/o_error on the next edge. i_start during LEN_LO..CHECK is ignored.
- i_rx_valid in IDLE, RUN or ERROR is ignored.
- Simultaneous i_start and i_rx_valid in IDLE/RUN/ERROR: the byte is dropped and the state goes to LEN_LO.
- o_wr_en is never high outside the cycle after a DATA_HI strobe.
- Address width: the counter is NB_COUNT wide. o_wr_addr is its low LOG2_N_INSMEM_ADDR bits; the range check guarantees no wrap.
- Outputs are registered, with no combinational path from input to output.
- Integration: bip_program_memory gains a synchronous write port (i_wr, i_wr_addr, i_wr_data). The BIP top routes o_cpu_valid to i_valid.

Decomposition:
- Shared package: state encoding localparams (8 states, 3 bits) and stream-format constants (LEN_BYTES=2, CHK_BYTES=1).
- One natural sub-module: bip_loader_word_assembler. It holds the LO latch, the {HI,LO} register and the write strobe; the FSM stays in the top.

Test Plan:
- Reset, then i_start, then bytes 02 00 01 08 02 10 19 -> writes (0,0x0801) and (1,0x1002); o_done=1, o_cpu_valid=1, o_word_count=2.
- Same stream with CHK=0x18 -> both writes still occur; o_error=1, o_cpu_valid=0, o_done=0.
- i_start, then 01 08 (N=0x0801=2049) -> ERROR right after LEN_HI, no o_wr_en ever asserted.
- i_start, then 00 00 00 (N=0, CHK=0) -> RUN with no writes; a following i_start returns to LEN_LO with o_cpu_valid=0.
- Reset low after the 3rd byte of test 1 -> next edge all outputs 0, state IDLE. Bytes strobed afterwards without i_start produce no writes.
- Full-depth stream of N=2048 words on back-to-back strobes, data = address, correct CHK -> 2048 writes at addresses 0..2047 with no gaps; final o_word_count=2048, RUN entered.
